// File: rtl/boron_round_ctrl.sv
// Iterative round sequencer for the Boron 64-bit block cipher: owns the cipher state,
// drives one external round datapath per clock and indexes the external key schedule.
module boron_round_ctrl #(
    parameter int unsigned ROUNDS = 25
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        dec_i,
    input  logic [63:0] data_i,
    input  logic [63:0] rk_i,
    input  logic [63:0] rnd_out_i,
    output logic [4:0]  rk_idx_o,
    output logic [63:0] rnd_in_o,
    output logic        dec_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] data_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } fsm_t;

    localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);
    localparam logic [4:0] LAST_KEY = 5'(ROUNDS);

    fsm_t        fsm_q, fsm_d;
    logic [63:0] state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        dec_q, dec_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] data_q, data_d;

    // NOTE: every signal written here gets a hold/default value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        data_d  = data_q;

        unique case (fsm_q)
            S_IDLE: begin
                if (start_i) begin
                    fsm_d   = S_ROUND;
                    state_d = data_i;
                    dec_d   = dec_i;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                end
            end
            S_ROUND: begin
                state_d = rnd_out_i;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == LAST_RND) begin
                    fsm_d = S_FINAL;
                end
            end
            S_FINAL: begin
                // Result is registered on the way into DONE so done_o and data_o
                // are both visible during the DONE cycle.
                state_d = state_q ^ rk_i;
                data_d  = state_q ^ rk_i;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                fsm_d   = S_DONE;
            end
            S_DONE: begin
                cnt_d = 5'd0;
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    // Encrypt walks keys 0..ROUNDS, decrypt walks ROUNDS..0.
    always_comb begin
        rk_idx_o = 5'd0;
        unique case (fsm_q)
            S_ROUND: rk_idx_o = dec_q ? (LAST_KEY - cnt_q) : cnt_q;
            S_FINAL: rk_idx_o = dec_q ? 5'd0 : LAST_KEY;
            default: rk_idx_o = 5'd0;
        endcase
    end

    assign rnd_in_o = state_q ^ rk_i;
    assign dec_o    = dec_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign data_o   = data_q;

endmodule
